// File: rtl/gf_vec_add_ctrl.sv
// Element-wise GF(2^WIDTH) vector adder sequencer (C = A xor B) driving a gf_add core.
// Optional runtime length port i_len is enabled by defining GF_VEC_ADD_LEN_EN.

module gf_add #(
  parameter int WIDTH   = 8,
  parameter int REG_IN  = 1,
  parameter int REG_OUT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_c,
  output logic             o_done
);

  logic [WIDTH-1:0] a_q, b_q;
  logic             s_q;

  generate
    if (REG_IN != 0) begin : g_in_reg
      // Data registers are intentionally not reset; only the strobe is.
      always_ff @(posedge i_clk) begin
        a_q <= i_a;
        b_q <= i_b;
      end
      always_ff @(posedge i_clk) begin
        if (i_rst) s_q <= 1'b0;
        else       s_q <= i_start;
      end
    end else begin : g_in_comb
      assign a_q = i_a;
      assign b_q = i_b;
      assign s_q = i_start;
    end

    if (REG_OUT != 0) begin : g_out_reg
      always_ff @(posedge i_clk) begin
        o_c <= a_q ^ b_q;
      end
      always_ff @(posedge i_clk) begin
        if (i_rst) o_done <= 1'b0;
        else       o_done <= s_q;
      end
    end else begin : g_out_comb
      assign o_c    = a_q ^ b_q;
      assign o_done = s_q;
    end
  endgenerate

endmodule

module gf_vec_add_ctrl #(
  parameter int WIDTH  = 8,
  parameter int N_ELEM = 16,
  parameter int ADDR_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
`ifdef GF_VEC_ADD_LEN_EN
  input  logic [ADDR_W:0]   i_len,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ab_en,
  output logic [ADDR_W-1:0] o_ab_addr,
  input  logic [WIDTH-1:0]  i_a_data,
  input  logic [WIDTH-1:0]  i_b_data,
  output logic              o_c_we,
  output logic [ADDR_W-1:0] o_c_addr,
  output logic [WIDTH-1:0]  o_c_data
);

  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] N_L = LEN_W'(N_ELEM);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q, len_eff, rd_idx, wr_idx;
  logic [2:0]       vld;
  logic             unused_adder_done;

  always_comb begin
    len_eff = N_L;
`ifdef GF_VEC_ADD_LEN_EN
    if (i_len <= N_L) len_eff = i_len;
`endif
  end

  assign o_c_we = vld[2];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      len_q     <= '0;
      rd_idx    <= '0;
      wr_idx    <= '0;
      vld       <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_ab_en   <= 1'b0;
      o_ab_addr <= '0;
      o_c_addr  <= '0;
    end else begin
      vld <= {vld[1:0], o_ab_en};
      // Address is loaded one cycle ahead so it lines up with the write strobe.
      if (vld[1]) begin
        o_c_addr <= wr_idx[ADDR_W-1:0];
        wr_idx   <= wr_idx + 1'b1;
      end
      case (state)
        IDLE: begin
          if (i_start) begin
            len_q  <= len_eff;
            wr_idx <= '0;
            if (len_eff == '0) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state     <= RUN;
              o_busy    <= 1'b1;
              o_ab_en   <= 1'b1;
              o_ab_addr <= '0;
              rd_idx    <= LEN_W'(1);
            end
          end
        end
        RUN: begin
          if (rd_idx == len_q) begin
            o_ab_en <= 1'b0;
            state   <= DRAIN;
          end else begin
            o_ab_addr <= rd_idx[ADDR_W-1:0];
            rd_idx    <= rd_idx + 1'b1;
          end
        end
        DRAIN: begin
          if (wr_idx == len_q) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  gf_add #(
    .WIDTH  (WIDTH),
    .REG_IN (1),
    .REG_OUT(1)
  ) u_add (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(vld[0]),
    .i_a    (i_a_data),
    .i_b    (i_b_data),
    .o_c    (o_c_data),
    .o_done (unused_adder_done)
  );

endmodule

// File: tb/tb_gf_vec_add_ctrl.sv
// Directed, table-driven bench for gf_vec_add_ctrl with behavioural A/B/C RAMs.

module tb_gf_vec_add_ctrl;

  localparam int N  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, start;
  logic          busy, done, ab_en, c_we;
  logic [AW-1:0] ab_addr, c_addr;
  logic [7:0]    a_data, b_data, c_data;
`ifdef GF_VEC_ADD_LEN_EN
  logic [AW:0]   len;
`endif

  logic [7:0] mem_a [N];
  logic [7:0] mem_b [N];
  logic [7:0] mem_c [N];
  logic       clr_c = 1'b0;
  int         wr_cnt = 0;
  int         done_cnt = 0;

  int nvec = 0;
  int nmis = 0;
  logic [7:0] cur_b;

  typedef struct {
    bit start;
    bit busy;
    bit done;
    bit ab_en;
    int ab_addr;
    bit c_we;
    int c_addr;
  } vec_t;
  vec_t tbl [32];
  int   tbl_n;

  always #5 clk = ~clk;

  gf_vec_add_ctrl #(.WIDTH(8), .N_ELEM(N)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
`ifdef GF_VEC_ADD_LEN_EN
    .i_len    (len),
`endif
    .o_busy   (busy),
    .o_done   (done),
    .o_ab_en  (ab_en),
    .o_ab_addr(ab_addr),
    .i_a_data (a_data),
    .i_b_data (b_data),
    .o_c_we   (c_we),
    .o_c_addr (c_addr),
    .o_c_data (c_data)
  );

  always @(posedge clk) begin
    if (ab_en) begin
      a_data <= mem_a[ab_addr];
      b_data <= mem_b[ab_addr];
    end
    if (clr_c) begin
      for (int i = 0; i < N; i++) mem_c[i] <= 8'hEE;
    end else if (c_we) begin
      mem_c[c_addr] <= c_data;
      wr_cnt = wr_cnt + 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_b(input logic [7:0] v);
    cur_b = v;
    for (int i = 0; i < N; i++) mem_b[i] = v;
  endtask

  // Expected per-cycle outputs for a run of length L started in cycle 0.
  task automatic build_table(input int L);
    tbl_n = L + 5;
    for (int c = 0; c < tbl_n; c++) begin
      tbl[c].start   = (c == 0);
      tbl[c].ab_addr = c - 1;
      tbl[c].c_addr  = c - 4;
      if (L > 0) begin
        tbl[c].busy  = (c >= 1) && (c <= L + 3);
        tbl[c].done  = (c == L + 4);
        tbl[c].ab_en = (c >= 1) && (c <= L);
        tbl[c].c_we  = (c >= 4) && (c <= L + 3);
      end else begin
        tbl[c].busy  = 1'b0;
        tbl[c].done  = (c == 1);
        tbl[c].ab_en = 1'b0;
        tbl[c].c_we  = 1'b0;
      end
    end
  endtask

  task automatic run_table(input bit extra_starts);
    for (int c = 0; c < tbl_n; c++) begin
      start = tbl[c].start | (extra_starts && (c == 3 || c == 19 || c == 20));
      @(negedge clk);
      chk($sformatf("busy@%0d", c), int'(busy), int'(tbl[c].busy));
      chk($sformatf("done@%0d", c), int'(done), int'(tbl[c].done));
      chk($sformatf("ab_en@%0d", c), int'(ab_en), int'(tbl[c].ab_en));
      chk($sformatf("c_we@%0d", c), int'(c_we), int'(tbl[c].c_we));
      if (tbl[c].ab_en)
        chk($sformatf("ab_addr@%0d", c), int'(ab_addr), tbl[c].ab_addr);
      if (tbl[c].c_we) begin
        chk($sformatf("c_addr@%0d", c), int'(c_addr), tbl[c].c_addr);
        chk($sformatf("c_data@%0d", c), int'(c_data), (tbl[c].c_addr & 8'hFF) ^ int'(cur_b));
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic check_c(input int n);
    for (int i = 0; i < n; i++)
      chk($sformatf("mem_c[%0d]", i), int'(mem_c[i]), i ^ int'(cur_b));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_ab_en"}, int'(ab_en), 0);
    chk({tag, "_c_we"}, int'(c_we), 0);
    chk({tag, "_ab_addr"}, int'(ab_addr), 0);
    chk({tag, "_c_addr"}, int'(c_addr), 0);
  endtask

  int w0, w1, d0;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
`ifdef GF_VEC_ADD_LEN_EN
    len   = 5'(N);
`endif
    for (int i = 0; i < N; i++) mem_a[i] = 8'(i);
    set_b(8'hFF);
    step(); step(); step();
    @(negedge clk);
    check_idle_outputs("reset");
    step();
    rst = 1'b0;
    step();

    // Basic run
    build_table(N);
    w0 = wr_cnt; d0 = done_cnt;
    run_table(1'b0);
    chk("basic_writes", wr_cnt - w0, N);
    chk("basic_dones", done_cnt - d0, 1);
    check_c(N);

    // Starts during RUN/DRAIN/DONE are dropped
    set_b(8'h3C);
    w0 = wr_cnt; d0 = done_cnt;
    run_table(1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("no_queue_busy%0d", k), int'(busy), 0);
      step();
    end
    chk("ignored_writes", wr_cnt - w0, N);
    chk("ignored_dones", done_cnt - d0, 1);
    check_c(N);

    // Back-to-back: second start in cycle 21
    set_b(8'h81);
    run_table(1'b0);
    check_c(N);
    set_b(8'h42);
    w0 = wr_cnt;
    run_table(1'b0);
    chk("b2b_writes", wr_cnt - w0, N);
    check_c(N);

    // Reset asserted in cycle 8 of a run
    clr_c = 1'b1;
    step();
    clr_c = 1'b0;
    set_b(8'h5A);
    w0 = wr_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    w1 = wr_cnt;
    step();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_we%0d", k), int'(c_we), 0);
      chk($sformatf("midrst_busy%0d", k), int'(busy), 0);
      step();
    end
    chk("midrst_writes", w1 - w0, 5);
    chk("midrst_no_late", wr_cnt - w1, 0);
    for (int i = 0; i < N; i++)
      chk($sformatf("midrst_c[%0d]", i), int'(mem_c[i]), (i < 5) ? (i ^ 8'h5A) : 8'hEE);
    build_table(N);
    run_table(1'b0);
    check_c(N);

`ifdef GF_VEC_ADD_LEN_EN
    set_b(8'hA5);
    len = 5'd1;
    build_table(1);
    w0 = wr_cnt;
    run_table(1'b0);
    chk("len1_writes", wr_cnt - w0, 1);
    check_c(1);

    len = 5'd0;
    build_table(0);
    w0 = wr_cnt; d0 = done_cnt;
    run_table(1'b0);
    chk("len0_writes", wr_cnt - w0, 0);
    chk("len0_dones", done_cnt - d0, 1);

    set_b(8'h0F);
    len = 5'd31;
    build_table(N);
    w0 = wr_cnt;
    run_table(1'b0);
    chk("len31_writes", wr_cnt - w0, N);
    check_c(N);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
